// File: rtl/pwm_seq_pkg.sv
// Shared types and the saturating duty-step helper for the PWM ramp sequencer.
package pwm_seq_pkg;

   typedef enum logic [1:0] {IDLE, WALK, LOAD} seq_state_t;

   // Widest duty the helper handles; callers zero-extend narrower duties.
   localparam int SEQ_W = 32;

   // One ramp step of cur toward tgt. A zero step jumps straight to tgt.
   // Math is one bit wider than the operands, so it saturates at tgt
   // instead of wrapping past it.
   function automatic logic [SEQ_W-1:0] step_toward(input logic [SEQ_W-1:0] cur,
                                                    input logic [SEQ_W-1:0] tgt,
                                                    input logic [SEQ_W-1:0] stp);
      logic [SEQ_W:0] sum;
      logic [SEQ_W:0] gap;
      sum = {1'b0, cur} + {1'b0, stp};
      gap = {1'b0, cur} - {1'b0, tgt};
      if (stp == '0)
         return tgt;
      else if (cur < tgt)
         return (sum > {1'b0, tgt}) ? tgt : sum[SEQ_W-1:0];
      else if (cur > tgt)
         return ({1'b0, stp} >= gap) ? tgt : (cur - stp);
      else
         return cur;
   endfunction

endpackage

// File: rtl/pwm_seq_divider.sv
// Period-interval divider: one trigger every interval+1 period_end pulses.
module pwm_seq_divider #(
   parameter int DIV_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             period_end,
   input  logic [DIV_W-1:0] interval,
   output logic             trig
);

   logic [DIV_W-1:0] div_cnt;

   // Trigger is combinational so the pass starts on the edge that samples it.
   assign trig = enable && period_end && (div_cnt == interval);

   // Count period ends; disabled holds the count at zero.
   always_ff @(posedge clock) begin
      if (reset || !enable)
         div_cnt <= '0;
      else if (period_end)
         div_cnt <= (div_cnt == interval) ? '0 : div_cnt + 1'b1;
   end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramp scheduler: walks every channel's duty toward its target once per
// trigger, then strobes duty_load so the PWM core latches all duties together.
module pwm_duty_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int NUM_CH = 4,    // 2..16
   parameter int CNT_W  = 16,   // up to SEQ_W
   parameter int DIV_W  = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [DIV_W-1:0]          interval,
   input  logic                      period_end,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]          cfg_target,
   input  logic [CNT_W-1:0]          cfg_step,
   output logic [NUM_CH*CNT_W-1:0]   duty_out,
   output logic                      duty_load,
   output logic [NUM_CH-1:0]         at_target,
   output logic                      done_irq,
   output logic                      overrun,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [IDX_W:0]   NUM_CH_L = (IDX_W + 1)'(NUM_CH);

   seq_state_t                     state;
   logic [IDX_W-1:0]               idx;
   logic                           pending;
   logic                           done_flag;
   logic [NUM_CH-1:0][CNT_W-1:0]   cur_q;
   logic [NUM_CH-1:0][CNT_W-1:0]   tgt_q;
   logic [NUM_CH-1:0][CNT_W-1:0]   stp_q;

   logic                           trig;
   logic [CNT_W-1:0]               cur_next;
   logic                           reach;
   logic                           cfg_hit;

   pwm_seq_divider #(.DIV_W(DIV_W)) u_div (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .period_end (period_end),
      .interval   (interval),
      .trig       (trig)
   );

   assign cfg_ready = (state == IDLE) && !reset;
   assign busy      = (state != IDLE);
   assign duty_out  = cur_q;
   // Out-of-range channel indices complete the handshake but write nothing.
   assign cfg_hit   = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < NUM_CH_L);

   // Next duty for the channel being walked, and whether it lands on target now.
   always_comb begin
      cur_next = CNT_W'(step_toward(SEQ_W'(cur_q[idx]), SEQ_W'(tgt_q[idx]), SEQ_W'(stp_q[idx])));
      reach    = (cur_q[idx] != tgt_q[idx]) && (cur_next == tgt_q[idx]);
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_at
         assign at_target[g] = (cur_q[g] == tgt_q[g]);
      end
   endgenerate

   // Sequencer FSM, channel registers, and pending/overrun bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         pending   <= 1'b0;
         overrun   <= 1'b0;
         done_flag <= 1'b0;
         duty_load <= 1'b0;
         done_irq  <= 1'b0;
         cur_q     <= '0;
         tgt_q     <= '0;
         stp_q     <= '0;
      end else begin
         duty_load <= 1'b0;
         done_irq  <= 1'b0;

         if (cfg_hit) begin
            tgt_q[cfg_ch] <= cfg_target;
            stp_q[cfg_ch] <= cfg_step;
         end

         case (state)
            IDLE: begin
               // A fresh trigger and a queued one collapse into a single pass.
               if (trig || (pending && enable)) begin
                  state     <= WALK;
                  idx       <= '0;
                  pending   <= 1'b0;
                  done_flag <= 1'b0;
               end
            end
            WALK: begin
               cur_q[idx] <= cur_next;
               if (reach)
                  done_flag <= 1'b1;
               if (idx == LAST_IDX) begin
                  state     <= LOAD;
                  duty_load <= 1'b1;
                  done_irq  <= done_flag || reach;
                  done_flag <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            LOAD: state <= IDLE;
            default: state <= IDLE;
         endcase

         // One trigger can queue behind a running pass; a second one is lost.
         if (trig && (state != IDLE)) begin
            if (pending)
               overrun <= 1'b1;
            else
               pending <= 1'b1;
         end

         // Disabling lets the current pass finish but drops any queued one.
         if (!enable)
            pending <= 1'b0;
      end
   end

endmodule
